// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory image loader.
//   state_e         : loader FSM states (CKSUM/ERROR only reachable when the
//                     IMEM_LOADER_CHECKSUM_EN build macro is defined)
//   BYTES_PER_WORD  : stream bytes per instruction word (little-endian)
//   DEFAULT_ADDR_W  : default word-address width of the init interface
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CKSUM = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (one header byte N, then N+1 little-endian 32-bit
// words) and writes the words to instruction memory starting at address 0.
// The core is held in reset until the whole image has been written.
//
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte (XOR of
// header and all data bytes). A mismatch parks the loader in ERROR.
//
// Ports:
//   CLK, reset_n       clock (rising edge), asynchronous active-low reset
//   start              single-cycle pulse; honoured in IDLE, DONE, ERROR
//   byte_valid/ready   byte stream handshake, byte_data is the payload
//   init_en            loader owns the instruction-memory port
//   init_addr          word write address
//   init_wdata         assembled word
//   init_we            one-cycle write strobe
//   core_reset         active-high reset to the core (low only in DONE)
//   done               image loaded, core running
//   load_err           checksum mismatch (tied 0 without the checksum build)
//   dbg_state          current FSM state, for observation only
//
// Handshake: a byte transfers on a rising CLK edge where byte_valid and
// byte_ready are both high; byte_data is sampled only on such an edge.
// byte_ready depends only on the state (HDR, DATA, CKSUM), never on
// byte_valid, and byte_valid without byte_ready is simply ignored.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = 256
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              init_en,
  output logic [ADDR_W-1:0] init_addr,
  output logic [31:0]       init_wdata,
  output logic              init_we,
  output logic              core_reset,
  output logic              done,
  output logic              load_err,
  output state_e            dbg_state
);

  // The header byte addresses the whole memory, so capacity must be 2**ADDR_W.
  if (MAX_WORDS != (1 << ADDR_W)) begin : g_cfg_check
    $error("imem_loader: MAX_WORDS must equal 2**ADDR_W");
  end

  state_e            state;
  state_e            state_nxt;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] last_addr;
  logic              xfer;
  logic              last_hit;

  assign xfer      = byte_valid & byte_ready;
  assign last_hit  = (init_addr == last_addr);
  assign dbg_state = state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] cksum;
  assign load_err = (state == ERROR);
`else
  assign load_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    init_en    = 1'b1;
    init_we    = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        init_en = 1'b0;
        if (start) state_nxt = HDR;
      end
      HDR: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = DATA;
      end
      DATA: begin
        byte_ready = 1'b1;
        if (xfer && (byte_idx == 2'(BYTES_PER_WORD - 1))) state_nxt = WRITE;
      end
      WRITE: begin
        init_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_nxt = last_hit ? CKSUM : DATA;
`else
        state_nxt = last_hit ? DONE : DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CKSUM: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = (byte_data == cksum) ? DONE : ERROR;
      end
      ERROR: begin
        init_en = 1'b0;
        if (start) state_nxt = HDR;
      end
`endif
      DONE: begin
        init_en    = 1'b0;
        core_reset = 1'b0;
        done       = 1'b1;
        if (start) state_nxt = HDR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address, word assembly, byte index and header capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      init_addr  <= '0;
      init_wdata <= '0;
      byte_idx   <= 2'd0;
      last_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cksum      <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          // Every (re)load writes from address 0.
          if (start) begin
            init_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum     <= 8'd0;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            last_addr <= ADDR_W'(byte_data);
            byte_idx  <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum     <= byte_data;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
            init_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum    <= cksum ^ byte_data;
`endif
          end
        end
        WRITE: begin
          byte_idx <= 2'd0;
          // Stop at the last address instead of incrementing, so a full
          // 256-word image never wraps the address back to 0.
          if (!last_hit) init_addr <= init_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. A write monitor logs every init_we cycle
// into got_q and a local memory image; each test builds exp_q and compares.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum option.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       CLK = 1'b0;
  logic       reset_n;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       init_en;
  logic [7:0] init_addr;
  logic [31:0] init_wdata;
  logic       init_we;
  logic       core_reset;
  logic       done;
  logic       load_err;
  state_e     dbg_state;

  always #5 CLK = ~CLK;

  imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .init_en    (init_en),
    .init_addr  (init_addr),
    .init_wdata (init_wdata),
    .init_we    (init_we),
    .core_reset (core_reset),
    .done       (done),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  logic [31:0] mem [0:255];
  logic [31:0] img [0:255];

  // ---------------------------------------------------------------------------
  // Scoreboard: write monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (reset_n && init_we) begin
      got_q.push_back({init_addr, init_wdata});
      mem[init_addr] = init_wdata;
      tests_run++;
      if (byte_ready !== 1'b0 || init_en !== 1'b1) begin
        tests_failed++;
        $display("FAIL write_cycle_ctrl: ready=%b en=%b required ready=0 en=1", byte_ready, init_en);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    if (byte_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
    end
    @(negedge CLK);
    byte_valid = 1'b0;
    byte_data  = 8'hxx;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Header, words img[0..hdr], optional checksum; ends on the first DONE cycle.
  task automatic send_image(input logic [7:0] hdr);
    logic [7:0] cs;
    logic [7:0] b;
    send_byte(hdr);
    cs = hdr;
    for (int w = 0; w <= int'(hdr); w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        send_byte(b);
        cs = cs ^ b;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    @(negedge CLK);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tests_run++;
    if ({byte_ready, init_en, init_we, core_reset, done, load_err} !== 6'b000100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready,en,we,crst,done,err=%b required 000100",
               {byte_ready, init_en, init_we, core_reset, done, load_err});
    end
    tests_run++;
    if (init_addr !== 8'h00 || init_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h required 00 00000000", init_addr, init_wdata);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (dbg_state !== IDLE || core_reset !== 1'b1 || init_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: state=%0d crst=%b en=%b required IDLE 1 0", dbg_state, core_reset, init_en);
    end
  endtask

  task automatic test_two_words();
    got_q.delete();
    exp_q = '{{8'h00, 32'h00000513}, {8'h01, 32'h00100093}};
    pulse_start();
    tests_run++;
    if (init_en !== 1'b1 || byte_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hdr_ctrl: en=%b ready=%b required 1 1", init_en, byte_ready);
    end
    img[0] = 32'h00000513;
    img[1] = 32'h00100093;
    send_image(8'h01);
    tests_run++;
    if (done !== 1'b1 || core_reset !== 1'b0 || init_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_words_done: done=%b crst=%b en=%b required 1 0 0", done, core_reset, init_en);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL two_words_count: writes=%0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL two_words_write%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] bytes [0:4];
    logic [7:0] cs;
    bytes = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    got_q.delete();
    pulse_start();
    cs = 8'h00;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom_range(0, 255));
        @(negedge CLK);
      end
      send_byte(bytes[i]);
      cs = cs ^ bytes[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    send_byte(cs);
`else
    @(negedge CLK);
`endif
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done: done=%b required 1", done);
    end
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== {8'h00, 32'hDDCCBBAA}) begin
      tests_failed++;
      $display("FAIL stall_write: count=%0d first=%h required 1 00ddccbbaa",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 40'h0);
    end
    // Valid bytes offered while DONE must be refused and cause no writes.
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (3) begin
      @(negedge CLK);
      tests_run++;
      if (byte_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_ready: ready=%b required 0", byte_ready);
      end
    end
    byte_valid = 1'b0;
    tests_run++;
    if (got_q.size() != 1) begin
      tests_failed++;
      $display("FAIL done_no_write: writes=%0d required 1", got_q.size());
    end
  endtask

  task automatic test_full_image();
    logic [7:0] b;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      img[i] = {b, ~b, 8'h3C, b + 8'd1};
      exp_q.push_back({b, b, ~b, 8'h3C, b + 8'd1});
    end
    pulse_start();
    send_image(8'hFF);
    tests_run++;
    if (done !== 1'b1 || init_addr !== 8'hFF) begin
      tests_failed++;
      $display("FAIL full_done: done=%b addr=%h required 1 ff", done, init_addr);
    end
    tests_run++;
    if (got_q.size() != 256) begin
      tests_failed++;
      $display("FAIL full_count: writes=%0d required 256", got_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL full_write%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] part [0:5];
    part = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(part[i]);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (dbg_state !== IDLE || {byte_ready, init_en, core_reset, done} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL async_reset_ctrl: state=%0d ready,en,crst,done=%b required IDLE 0010",
               dbg_state, {byte_ready, init_en, core_reset, done});
    end
    tests_run++;
    if (init_addr !== 8'h00 || init_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset_data: addr=%h wdata=%h required 00 00000000", init_addr, init_wdata);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    got_q.delete();
    exp_q = '{{8'h00, 32'h89ABCDEF}, {8'h01, 32'h01234567}};
    img[0] = 32'h89ABCDEF;
    img[1] = 32'h01234567;
    pulse_start();
    send_image(8'h01);
    tests_run++;
    if (done !== 1'b1 || got_q.size() != 2) begin
      tests_failed++;
      $display("FAIL post_reset_load: done=%b writes=%0d required 1 2", done, got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL post_reset_write%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reload();
    pulse_start();
    tests_run++;
    if (core_reset !== 1'b1 || done !== 1'b0 || dbg_state !== HDR) begin
      tests_failed++;
      $display("FAIL reload_start: crst=%b done=%b state=%0d required 1 0 HDR", core_reset, done, dbg_state);
    end
    got_q.delete();
    send_byte(8'h00);
    send_byte(8'h0D);
    send_byte(8'hF0);
    pulse_start();
    tests_run++;
    if (dbg_state !== DATA || init_addr !== 8'h00 || core_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_in_data: state=%0d addr=%h crst=%b required DATA 00 1", dbg_state, init_addr, core_reset);
    end
    send_byte(8'hFE);
    send_byte(8'hCA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 ^ 8'h0D ^ 8'hF0 ^ 8'hFE ^ 8'hCA);
`else
    @(negedge CLK);
`endif
    tests_run++;
    if (done !== 1'b1 || got_q.size() != 1) begin
      tests_failed++;
      $display("FAIL reload_done: done=%b writes=%0d required 1 1", done, got_q.size());
    end
    tests_run++;
    if (mem[0] !== 32'hCAFEF00D || mem[1] !== 32'h01234567) begin
      tests_failed++;
      $display("FAIL reload_mem: mem0=%h mem1=%h required cafef00d 01234567", mem[0], mem[1]);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] seq [0:4];
    seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(seq[i]);
    send_byte(8'h04);
    tests_run++;
    if (done !== 1'b1 || load_err !== 1'b0 || core_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL cksum_match: done=%b err=%b crst=%b required 1 0 0", done, load_err, core_reset);
    end
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(seq[i]);
    send_byte(8'h05);
    tests_run++;
    if (load_err !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL cksum_mismatch: err=%b crst=%b done=%b required 1 1 0", load_err, core_reset, done);
    end
    pulse_start();
    tests_run++;
    if (load_err !== 1'b0 || dbg_state !== HDR) begin
      tests_failed++;
      $display("FAIL cksum_restart: err=%b state=%0d required 0 HDR", load_err, dbg_state);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    @(negedge CLK);
    test_reset();
    test_two_words();
    test_stall();
    test_full_image();
    test_async_reset();
    test_reload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
